fib_sched: RTL
==============

Name: fib_sched

Overview:
- Round-robin scheduler that shares one Fibonacci compute unit between N_REQ requesters.
- Accepts per-requester index requests and grants one at a time.
- Sequences the unit's start/done handshake, then returns the result to the granted requester with a one-cycle response pulse.
- Sits between client blocks and the Fibonacci controller/datapath pair; adds a done-timeout watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDX_W, 5, width of the Fibonacci index (matches the unit's i port).
- RES_W, 32, width of the result.
- TIMEOUT, 64, max cycles spent in WAIT before abort (>=2).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately).
- req  in  N_REQ  per-requester request level.
- req_idx  in  N_REQ*IDX_W  packed indices; requester k uses bits [k*IDX_W +: IDX_W].
- gnt  out  N_REQ  one-hot grant, held from issue through response.
- rsp_valid  out  N_REQ  one-hot, one-cycle response pulse.
- rsp_data  out  RES_W  result, valid when any rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when the response is a timeout abort (rsp_data=0).
- fib_start  out  1  one-cycle start pulse to the compute unit.
- fib_i  out  IDX_W  index to the compute unit, stable from ISSUE through WAIT.
- fib_done  in  1  one-cycle completion pulse from the compute unit.
- fib_result  in  RES_W  compute unit result, sampled when fib_done=1.
- busy  out  1  high in every state except IDLE.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Interface contract:
  - Moore outputs only; no combinational path from any input to any output.
  - Reset values: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, fib_start=0, fib_i=0, busy=0, timeout_flag=0.
  - Internal reset values: rr pointer=N_REQ-1, so requester 0 has first priority; wait counter=0; state=IDLE.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is high, select the first requester set at or after (ptr+1) mod N_REQ, wrapping.
  - Register gnt onehot and latch req_idx of the winner into fib_i; go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: fib_start=1 for exactly this cycle; clear the wait counter; go to WAIT.
- WAIT:
  - If fib_done=1: capture fib_result into rsp_data, rsp_err=0, go to RESP.
  - Else, if counter==TIMEOUT-1: rsp_data=0, rsp_err=1, set timeout_flag, go to RESP.
  - Otherwise: increment the counter.
  - fib_done takes priority over timeout in the same cycle.
- RESP:
  - rsp_valid = gnt for one cycle; ptr <= index of the granted requester.
  - Go to IDLE; gnt is cleared on that edge.
- Latency: req sampled high in IDLE at edge 0 → fib_start high in cycle 1; rsp_valid in the cycle after fib_done was sampled.
- Minimum turnaround is 3 cycles plus the unit's latency. A new grant is possible in the cycle after RESP.
- Requester rules:
  - Hold req and req_idx stable until its rsp_valid.
  - Drop req on the edge ending the rsp_valid cycle, otherwise it is re-arbitrated as a new request.
  - Changes to req_idx after the grant are ignored; fib_i is latched.
  - Dropping req while granted does not abort the transaction; the response is still issued.
- Other inputs:
  - fib_done outside WAIT is ignored.
  - Index 0 is legal and is passed through unchanged.
- Reset mid-operation: immediate return to reset values; any in-flight transaction is lost and no rsp_valid is produced.
- Fairness: with all N_REQ requesting continuously, each requester is served once every N_REQ transactions.

Test Plan:
- Reset then req=4'b0001, idx=10, unit returns 55 after 12 cycles → fib_start pulse in cycle 1, gnt=0001, rsp_valid=0001 with rsp_data=55, rsp_err=0.
- req=4'b1111 held continuously → grant order 0,1,2,3,0; each rsp_valid one-hot matches the preceding gnt.
- ptr=1, then req=4'b0101 simultaneously → requester 2 granted before requester 0 (wrap-around).
- fib_done never asserted, TIMEOUT=64 → rsp_valid after 64 WAIT cycles, rsp_err=1, rsp_data=0; timeout_flag stays 1 through later successful transactions.
- fib_done asserted in the same cycle the counter reaches TIMEOUT-1 → normal response, rsp_err=0, timeout_flag=0.
- rst driven 0 during WAIT → all outputs zero immediately; after release, a pending req from requester 3 is granted first only if no lower-index req is high.

Source files
------------

// File: rtl/fib_sched.sv
// Round-robin front end that shares one Fibonacci compute unit between N_REQ
// requesters, sequences its start/done handshake and aborts stalled runs.
module fib_sched #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 5,
  parameter int RES_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [RES_W-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   fib_start,
  output logic [IDX_W-1:0]       fib_i,
  input  logic                   fib_done,
  input  logic [RES_W-1:0]       fib_result,
  output logic                   busy,
  output logic                   timeout_flag
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] win_idx;
  logic             win_found;
  logic [CNT_W-1:0] cnt;
  logic             timeout_hit;

  assign timeout_hit = (cnt == CNT_LAST);

  // Search starts one past the last served requester so service rotates.
  always_comb begin
    int               cand;
    logic [PTR_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (win_found) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (fib_done || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A completion arriving on the last allowed cycle still wins over the abort.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr          <= PTR_INIT;
      gnt_idx      <= '0;
      gnt          <= '0;
      fib_i        <= '0;
      cnt          <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt     <= N_REQ'(1) << win_idx;
            gnt_idx <= win_idx;
            fib_i   <= req_idx[int'(win_idx)*IDX_W +: IDX_W];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (fib_done) begin
            rsp_data <= fib_result;
            rsp_err  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data     <= '0;
            rsp_err      <= 1'b1;
            timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          ptr <= gnt_idx;
          gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP) ? gnt : '0;
  assign fib_start = (state == ISSUE);
  assign busy      = (state != IDLE);

endmodule
